// File: rtl/axis_word_packer.sv
// axis_word_packer: packs RATIO narrow AXI-Stream beats into one wide word.
//
// Lane k of the output word (bits [k*IN_DW +: IN_DW]) holds the k-th accepted beat of that word.
// A word closes on the beat that fills the last lane or carries tlast, whichever comes first.
// Lanes left unfilled by a tlast read zero and have their tkeep bits cleared.
//
// Optional feature (macro AXIS_PACKER_WORD_COUNT_EN): adds a 32-bit word_count output that
// counts output handshakes since reset and wraps.
//
// Ports:
//   clk, resetn      clock (rising edge), synchronous active-low reset
//   s_axis_tdata     input beat data, IN_DW bits
//   s_axis_tvalid    input beat valid
//   s_axis_tlast     input beat closes a packet
//   s_axis_tready    input beat accepted when tvalid & tready
//   m_axis_tdata     packed word, IN_DW*RATIO bits
//   m_axis_tkeep     per-lane valid mask, RATIO bits
//   m_axis_tlast     word closes a packet
//   m_axis_tvalid    output word valid
//   m_axis_tready    downstream accept
//   word_count       handshake counter (only with AXIS_PACKER_WORD_COUNT_EN)
module axis_word_packer #(
   parameter int unsigned IN_DW = 32,
   parameter int unsigned RATIO = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [IN_DW-1:0]       s_axis_tdata,
   input  logic                   s_axis_tvalid,
   input  logic                   s_axis_tlast,
   output logic                   s_axis_tready,
   output logic [IN_DW*RATIO-1:0] m_axis_tdata,
   output logic [RATIO-1:0]       m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready
`ifdef AXIS_PACKER_WORD_COUNT_EN
  ,output logic [31:0]            word_count
`endif
);

   localparam int unsigned OutDw = IN_DW * RATIO;
   localparam int unsigned LaneW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [LaneW-1:0] LastLane = LaneW'(RATIO - 1);

   typedef enum logic {StEmpty, StFill} state_e;

   state_e             state;
   logic [LaneW-1:0]   lane;
   logic [OutDw-1:0]   acc;

   logic [LaneW-1:0]   cur_lane;
   logic               accept;
   logic               complete;
   logic [OutDw-1:0]   merged;
   logic [RATIO-1:0]   keep_next;

   // Output register can take a new word when empty or being drained this cycle.
   assign s_axis_tready = resetn && (!m_axis_tvalid || m_axis_tready);
   assign accept        = s_axis_tvalid && s_axis_tready;

   // In EMPTY the lane is 0 by construction; gating on state keeps the FSM authoritative.
   assign cur_lane = (state == StEmpty) ? '0 : lane;
   assign complete = accept && (s_axis_tlast || (cur_lane == LastLane));

   always_comb begin
      merged = acc;
      merged[cur_lane*IN_DW +: IN_DW] = s_axis_tdata;
      keep_next = '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
         keep_next[i] = (i <= 32'(cur_lane));
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= StEmpty;
         lane          <= '0;
         acc           <= '0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else begin
         if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (accept) begin
            if (complete) begin
               // Accumulator is cleared so unfilled lanes of the next word read zero.
               m_axis_tdata  <= merged;
               m_axis_tkeep  <= keep_next;
               m_axis_tlast  <= s_axis_tlast;
               m_axis_tvalid <= 1'b1;
               acc           <= '0;
               lane          <= '0;
               state         <= StEmpty;
            end else begin
               acc   <= merged;
               lane  <= cur_lane + 1'b1;
               state <= StFill;
            end
         end
      end
   end

`ifdef AXIS_PACKER_WORD_COUNT_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         word_count <= '0;
      end else if (m_axis_tvalid && m_axis_tready) begin
         word_count <= word_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_word_packer.sv
// Self-checking bench for axis_word_packer (IN_DW=32, RATIO=4).
// A transaction-level model collects accepted beats into a list and emits a word when the list
// reaches RATIO beats or a tlast arrives; DUT outputs are compared against it every cycle.
module tb_axis_word_packer;

   localparam int unsigned InDw  = 32;
   localparam int unsigned Ratio = 4;
   localparam int unsigned OutDw = InDw * Ratio;

   logic               clk = 1'b0;
   logic               resetn = 1'b0;
   logic [InDw-1:0]    s_axis_tdata = '0;
   logic               s_axis_tvalid = 1'b0;
   logic               s_axis_tlast = 1'b0;
   logic               s_axis_tready;
   logic [OutDw-1:0]   m_axis_tdata;
   logic [Ratio-1:0]   m_axis_tkeep;
   logic               m_axis_tlast;
   logic               m_axis_tvalid;
   logic               m_axis_tready = 1'b0;
`ifdef AXIS_PACKER_WORD_COUNT_EN
   logic [31:0]        word_count;
`endif

   axis_word_packer #(.IN_DW(InDw), .RATIO(Ratio)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
`ifdef AXIS_PACKER_WORD_COUNT_EN
     ,.word_count    (word_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   logic [InDw-1:0]    beats[$];
   bit                 exp_valid = 0;
   logic [OutDw-1:0]   exp_data = '0;
   logic [Ratio-1:0]   exp_keep = '0;
   bit                 exp_last = 0;
   int unsigned        exp_count = 0;
   bit                 model_acc = 0;

   // Handshakes observed on the DUT output
   int dut_hs = 0;
   int dut_hs_last = 0;

   // Stimulus queue for drive()
   logic [InDw-1:0]    stim_d[$];
   bit                 stim_l[$];
   int                 last_cycles = 0;

   task automatic check(input string name, input logic [OutDw-1:0] act,
                        input logic [OutDw-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input bit rn, input bit sv, input logic [InDw-1:0] sd,
                               input bit sl, input bit mr);
      bit ready;
      model_acc = 0;
      if (!rn) begin
         beats.delete();
         exp_valid = 0;
         exp_data  = '0;
         exp_keep  = '0;
         exp_last  = 0;
         exp_count = 0;
         return;
      end
      ready = !exp_valid || mr;
      if (exp_valid && mr) begin
         exp_valid = 0;
         exp_count++;
      end
      if (sv && ready) begin
         model_acc = 1;
         beats.push_back(sd);
         if (sl || beats.size() == Ratio) begin
            exp_data = '0;
            exp_keep = '0;
            for (int i = 0; i < beats.size(); i++) begin
               exp_data[i*InDw +: InDw] = beats[i];
               exp_keep[i] = 1'b1;
            end
            exp_last  = sl;
            exp_valid = 1;
            beats.delete();
         end
      end
   endtask

   // One clock cycle: drive inputs, clock the model, then compare at the falling edge.
   task automatic step(input bit rn, input bit sv, input logic [InDw-1:0] sd,
                       input bit sl, input bit mr);
      resetn        = rn;
      s_axis_tvalid = sv;
      s_axis_tdata  = sd;
      s_axis_tlast  = sl;
      m_axis_tready = mr;
      #1;
      if (rn && m_axis_tvalid && mr) begin
         dut_hs++;
         if (m_axis_tlast) dut_hs_last++;
      end
      @(posedge clk);
      model_update(rn, sv, sd, sl, mr);
      @(negedge clk);
      check("s_tready", OutDw'(s_axis_tready), OutDw'(rn && (!exp_valid || mr)));
      check("m_tvalid", OutDw'(m_axis_tvalid), OutDw'(exp_valid));
      if (exp_valid) begin
         check("m_tdata", m_axis_tdata, exp_data);
         check("m_tkeep", OutDw'(m_axis_tkeep), OutDw'(exp_keep));
         check("m_tlast", OutDw'(m_axis_tlast), OutDw'(exp_last));
      end
`ifdef AXIS_PACKER_WORD_COUNT_EN
      check("word_count", OutDw'(word_count), OutDw'(exp_count));
`endif
   endtask

   task automatic push(input logic [InDw-1:0] d, input bit l);
      stim_d.push_back(d);
      stim_l.push_back(l);
   endtask

   // Present queued beats with random valid/ready duty, holding each beat until accepted.
   task automatic drive(input int pv, input int pr, input int budget);
      int i = 0;
      int cyc = 0;
      bit v;
      while (i < stim_d.size()) begin
         if (cyc >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL drive_budget: got %0d beats accepted expected %0d", i, stim_d.size());
            break;
         end
         v = ($urandom_range(99) < pv);
         step(1, v, v ? stim_d[i] : $urandom, v ? stim_l[i] : 1'b0, $urandom_range(99) < pr);
         if (model_acc) i++;
         cyc++;
      end
      last_cycles = cyc;
      stim_d.delete();
      stim_l.delete();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1, 0, '0, 0, 1);
   endtask

   initial begin
      int hs0;
      int hl0;

      // Reset state
      step(0, 0, '0, 0, 0);
      step(0, 1, 32'hDEAD_BEEF, 0, 1);
      check("rst_tvalid", OutDw'(m_axis_tvalid), '0);
      check("rst_tdata", m_axis_tdata, '0);
      check("rst_tkeep", OutDw'(m_axis_tkeep), '0);
      check("rst_tlast", OutDw'(m_axis_tlast), '0);
      check("rst_s_tready", OutDw'(s_axis_tready), '0);

      // Full word, valid one cycle after the 4th beat
      push(32'h1111_1111, 0);
      push(32'h2222_2222, 0);
      push(32'h3333_3333, 0);
      push(32'h4444_4444, 1);
      drive(100, 100, 10);
      check("full_cycles", OutDw'(last_cycles), OutDw'(4));
      check("full_valid", OutDw'(m_axis_tvalid), OutDw'(1));
      check("full_data", m_axis_tdata, 128'h44444444_33333333_22222222_11111111);
      check("full_keep", OutDw'(m_axis_tkeep), OutDw'(4'b1111));
      check("full_last", OutDw'(m_axis_tlast), OutDw'(1));
      idle(2);

      // Short packet
      push(32'hAAAA_0001, 0);
      push(32'hAAAA_0002, 1);
      drive(100, 100, 10);
      check("short_data", m_axis_tdata, 128'h00000000_00000000_AAAA0002_AAAA0001);
      check("short_keep", OutDw'(m_axis_tkeep), OutDw'(4'b0011));
      check("short_last", OutDw'(m_axis_tlast), OutDw'(1));
      idle(2);

      // Backpressure with a word pending, then a beat held at the input for 5 cycles
      push(32'h0000_00A0, 0);
      push(32'h0000_00A1, 0);
      push(32'h0000_00A2, 0);
      push(32'h0000_00A3, 0);
      drive(100, 0, 10);
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 32'h0000_00B0, 0, 0);
         check("bp_s_tready", OutDw'(s_axis_tready), '0);
      end
      check("bp_data", m_axis_tdata, 128'h000000A3_000000A2_000000A1_000000A0);
      push(32'h0000_00B0, 0);
      push(32'h0000_00B1, 0);
      push(32'h0000_00B2, 0);
      push(32'h0000_00B3, 0);
      drive(100, 100, 10);
      check("bp_next_data", m_axis_tdata, 128'h000000B3_000000B2_000000B1_000000B0);
      check("bp_next_last", OutDw'(m_axis_tlast), '0);
      idle(2);

      // Streaming: 64 beats, tlast every 8th
      step(0, 0, '0, 0, 1);
      hs0 = dut_hs;
      hl0 = dut_hs_last;
      for (int i = 0; i < 64; i++) push(32'(i) | 32'h5A00_0000, (i % 8) == 7);
      drive(100, 100, 100);
      idle(2);
      check("stream_cycles", OutDw'(last_cycles), OutDw'(64));
      check("stream_words", OutDw'(dut_hs - hs0), OutDw'(16));
      check("stream_last_words", OutDw'(dut_hs_last - hl0), OutDw'(8));
`ifdef AXIS_PACKER_WORD_COUNT_EN
      check("wc_after_stream", OutDw'(word_count), OutDw'(16));
      step(0, 0, '0, 0, 1);
      check("wc_after_reset", OutDw'(word_count), '0);
`endif

      // Random traffic
      for (int i = 0; i < 300; i++) push($urandom, $urandom_range(4) == 0);
      drive(70, 60, 3000);
      idle(3);

      // Reset mid-word
      push(32'hC000_0001, 0);
      push(32'hC000_0002, 0);
      drive(100, 100, 10);
      step(0, 0, '0, 0, 1);
      hs0 = dut_hs;
      push(32'hD000_0000, 0);
      push(32'hD000_0001, 0);
      push(32'hD000_0002, 0);
      push(32'hD000_0003, 0);
      drive(100, 100, 10);
      check("rstmid_data", m_axis_tdata, 128'hD0000003_D0000002_D0000001_D0000000);
      check("rstmid_keep", OutDw'(m_axis_tkeep), OutDw'(4'b1111));
      idle(3);
      check("rstmid_words", OutDw'(dut_hs - hs0), OutDw'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
